// File: rtl/axi_lite_ureg_slave_if.sv
// AXI4-Lite bus bundle for the PL user-register window.
// The master modport is the PS side; the slave modport is axi_lite_ureg_slave.
interface axi_lite_ureg_slave_if #(
  parameter int ADDR_W = 12
) ();
  logic [ADDR_W-1:0] s_awaddr;
  logic              s_awvalid;
  logic              s_awready;
  logic [31:0]       s_wdata;
  logic [3:0]        s_wstrb;
  logic              s_wvalid;
  logic              s_wready;
  logic [1:0]        s_bresp;
  logic              s_bvalid;
  logic              s_bready;
  logic [ADDR_W-1:0] s_araddr;
  logic              s_arvalid;
  logic              s_arready;
  logic [31:0]       s_rdata;
  logic [1:0]        s_rresp;
  logic              s_rvalid;
  logic              s_rready;

  modport master (
    output s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
    output s_araddr, s_arvalid, s_rready,
    input  s_awready, s_wready, s_bresp, s_bvalid,
    input  s_arready, s_rdata, s_rresp, s_rvalid
  );

  modport slave (
    input  s_awaddr, s_awvalid, s_wdata, s_wstrb, s_wvalid, s_bready,
    input  s_araddr, s_arvalid, s_rready,
    output s_awready, s_wready, s_bresp, s_bvalid,
    output s_arready, s_rdata, s_rresp, s_rvalid
  );
endinterface

// File: rtl/axi_lite_ureg_slave.sv
// AXI4-Lite responder for the user-register window: FW date/time (RO), TEST0/TEST1 (RW).
// Optional macro UREG_SLVERR_EN: SLVERR on unmapped reads and on unmapped/RO writes.
//
// Handshake rule for every channel: a transfer happens on the rising ACLK edge where
// VALID and READY are both 1; VALID, once raised, holds its payload until that edge.
module axi_lite_ureg_slave #(
  parameter int          ADDR_W    = 12,
  parameter logic [31:0] FW_DATE   = 32'h0000_0000,
  parameter logic [31:0] FW_TIME   = 32'h0000_0000,
  parameter logic [31:0] TEST0_RST = 32'h0000_0000,
  parameter logic [31:0] TEST1_RST = 32'h0000_0000
) (
  input  logic                     ACLK,
  input  logic                     ARESET,
  axi_lite_ureg_slave_if.slave     s,
  output logic [31:0]              ureg_test0,
  output logic [31:0]              ureg_test1,
  output logic                     ureg_wr_stb,
  output logic [1:0]               dbg_w_state_o,
  output logic                     dbg_r_state_o
);

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_GOTA, W_GOTD, W_RESP} w_state_e;
  typedef enum logic       {R_IDLE, R_DATA} r_state_e;

  w_state_e          w_state_q, w_state_d;
  r_state_e          r_state_q, r_state_d;

  logic [ADDR_W-1:2] awaddr_q, awaddr_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [3:0]        wstrb_q, wstrb_d;
  logic [31:0]       test0_q, test0_d;
  logic [31:0]       test1_q, test1_d;
  logic              wr_stb_q, wr_stb_d;
  logic              awready_q, awready_d;
  logic              wready_q, wready_d;
  logic              bvalid_q, bvalid_d;
  logic [1:0]        bresp_q, bresp_d;
  logic              arready_q, arready_d;
  logic              rvalid_q, rvalid_d;
  logic [31:0]       rdata_q, rdata_d;
  logic [1:0]        rresp_q, rresp_d;

  logic              aw_fire, w_fire, ar_fire;
  logic              commit;
  logic [ADDR_W-1:2] c_addr;
  logic [31:0]       c_data;
  logic [3:0]        c_strb;
  logic              c_mapped;
  logic              c_test;
  logic              r_mapped;
  logic              unused_addr_lsbs;

  // Byte lanes are word-aligned; the two LSBs never take part in decode.
  assign unused_addr_lsbs = ^{s.s_awaddr[1:0], s.s_araddr[1:0]};

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                              input logic [31:0] new_v,
                                              input logic [3:0]  strb);
    logic [31:0] res;
    for (int b = 0; b < 4; b++) begin
      res[b*8 +: 8] = strb[b] ? new_v[b*8 +: 8] : old_v[b*8 +: 8];
    end
    return res;
  endfunction

  // Write path: collect AW and W in either order, commit once both are present.
  always_comb begin
    w_state_d = w_state_q;
    awaddr_d  = awaddr_q;
    wdata_d   = wdata_q;
    wstrb_d   = wstrb_q;
    commit    = 1'b0;
    c_addr    = awaddr_q;
    c_data    = wdata_q;
    c_strb    = wstrb_q;
    aw_fire   = s.s_awvalid && awready_q;
    w_fire    = s.s_wvalid && wready_q;

    case (w_state_q)
      W_IDLE: begin
        if (aw_fire && w_fire) begin
          commit    = 1'b1;
          c_addr    = s.s_awaddr[ADDR_W-1:2];
          c_data    = s.s_wdata;
          c_strb    = s.s_wstrb;
          w_state_d = W_RESP;
        end else if (aw_fire) begin
          awaddr_d  = s.s_awaddr[ADDR_W-1:2];
          w_state_d = W_GOTA;
        end else if (w_fire) begin
          wdata_d   = s.s_wdata;
          wstrb_d   = s.s_wstrb;
          w_state_d = W_GOTD;
        end
      end
      W_GOTA: begin
        if (w_fire) begin
          commit    = 1'b1;
          c_data    = s.s_wdata;
          c_strb    = s.s_wstrb;
          w_state_d = W_RESP;
        end
      end
      W_GOTD: begin
        if (aw_fire) begin
          commit    = 1'b1;
          c_addr    = s.s_awaddr[ADDR_W-1:2];
          w_state_d = W_RESP;
        end
      end
      W_RESP: begin
        if (bvalid_q && s.s_bready) begin
          w_state_d = W_IDLE;
        end
      end
      default: w_state_d = W_IDLE;
    endcase

    c_mapped = (c_addr[ADDR_W-1:4] == '0);
    c_test   = c_mapped && c_addr[3];

    test0_d = test0_q;
    test1_d = test1_q;
    if (commit && c_test && !c_addr[2]) test0_d = merge_bytes(test0_q, c_data, c_strb);
    if (commit && c_test &&  c_addr[2]) test1_d = merge_bytes(test1_q, c_data, c_strb);

    wr_stb_d = commit && c_test && (c_strb != 4'b0000);

    bresp_d = bresp_q;
    if (commit) begin
`ifdef UREG_SLVERR_EN
      bresp_d = c_test ? RESP_OKAY : RESP_SLVERR;
`else
      bresp_d = RESP_OKAY;
`endif
    end

    awready_d = (w_state_d == W_IDLE) || (w_state_d == W_GOTD);
    wready_d  = (w_state_d == W_IDLE) || (w_state_d == W_GOTA);
    bvalid_d  = (w_state_d == W_RESP);
  end

  // Read path: sample the current register values, so a same-edge write is not seen.
  always_comb begin
    r_state_d = r_state_q;
    rdata_d   = rdata_q;
    rresp_d   = rresp_q;
    ar_fire   = s.s_arvalid && arready_q;
    r_mapped  = (s.s_araddr[ADDR_W-1:4] == '0);

    case (r_state_q)
      R_IDLE: begin
        if (ar_fire) begin
          r_state_d = R_DATA;
          rresp_d   = RESP_OKAY;
          if (!r_mapped) begin
            rdata_d = 32'h0000_0000;
`ifdef UREG_SLVERR_EN
            rresp_d = RESP_SLVERR;
`endif
          end else begin
            case (s.s_araddr[3:2])
              2'd0:    rdata_d = FW_DATE;
              2'd1:    rdata_d = FW_TIME;
              2'd2:    rdata_d = test0_q;
              default: rdata_d = test1_q;
            endcase
          end
        end
      end
      R_DATA: begin
        if (rvalid_q && s.s_rready) begin
          r_state_d = R_IDLE;
        end
      end
      default: r_state_d = R_IDLE;
    endcase

    arready_d = (r_state_d == R_IDLE);
    rvalid_d  = (r_state_d == R_DATA);
  end

  always_ff @(posedge ACLK) begin
    if (ARESET) begin
      w_state_q <= W_IDLE;
      r_state_q <= R_IDLE;
      awaddr_q  <= '0;
      wdata_q   <= '0;
      wstrb_q   <= '0;
      test0_q   <= TEST0_RST;
      test1_q   <= TEST1_RST;
      wr_stb_q  <= 1'b0;
      awready_q <= 1'b0;
      wready_q  <= 1'b0;
      bvalid_q  <= 1'b0;
      bresp_q   <= RESP_OKAY;
      arready_q <= 1'b0;
      rvalid_q  <= 1'b0;
      rdata_q   <= '0;
      rresp_q   <= RESP_OKAY;
    end else begin
      w_state_q <= w_state_d;
      r_state_q <= r_state_d;
      awaddr_q  <= awaddr_d;
      wdata_q   <= wdata_d;
      wstrb_q   <= wstrb_d;
      test0_q   <= test0_d;
      test1_q   <= test1_d;
      wr_stb_q  <= wr_stb_d;
      awready_q <= awready_d;
      wready_q  <= wready_d;
      bvalid_q  <= bvalid_d;
      bresp_q   <= bresp_d;
      arready_q <= arready_d;
      rvalid_q  <= rvalid_d;
      rdata_q   <= rdata_d;
      rresp_q   <= rresp_d;
    end
  end

  assign s.s_awready   = awready_q;
  assign s.s_wready    = wready_q;
  assign s.s_bvalid    = bvalid_q;
  assign s.s_bresp     = bresp_q;
  assign s.s_arready   = arready_q;
  assign s.s_rvalid    = rvalid_q;
  assign s.s_rdata     = rdata_q;
  assign s.s_rresp     = rresp_q;
  assign ureg_test0    = test0_q;
  assign ureg_test1    = test1_q;
  assign ureg_wr_stb   = wr_stb_q;
  assign dbg_w_state_o = w_state_q;
  assign dbg_r_state_o = r_state_q;

endmodule

// File: doc/axi_lite_ureg_slave.md
Name: axi_lite_ureg_slave

Overview:
AXI4-Lite responder for the PL user-register window at PS GP0 base 0x43C0_0000. It terminates PS7 master reads and writes, serves the read-only firmware date/time words, and holds two read/write test registers whose values are also driven to fabric. The PS is the only master, and the block sits between the AXI interconnect and user logic.

Parameters:
ADDR_W, 12, byte-address width of the window (the block decodes only ADDR_W LSBs).
FW_DATE, 32'h0000_0000, constant returned at offset 0x00.
FW_TIME, 32'h0000_0000, constant returned at offset 0x04.
TEST0_RST, 32'h0000_0000, reset value of TEST0.
TEST1_RST, 32'h0000_0000, reset value of TEST1.

Ports:
ACLK  in  1  clock for all logic.
ARESET  in  1  reset; active-high, synchronous to ACLK.
s_awaddr  in  ADDR_W  write address.
s_awvalid  in  1  write address valid.
s_awready  out  1  write address ready.
s_wdata  in  32  write data.
s_wstrb  in  4  byte strobes.
s_wvalid  in  1  write data valid.
s_wready  out  1  write data ready.
s_bresp  out  2  write response.
s_bvalid  out  1  write response valid.
s_bready  in  1  write response ready.
s_araddr  in  ADDR_W  read address.
s_arvalid  in  1  read address valid.
s_arready  out  1  read address ready.
s_rdata  out  32  read data.
s_rresp  out  2  read response.
s_rvalid  out  1  read valid.
s_rready  in  1  read ready.
ureg_test0  out  32  current TEST0 value.
ureg_test1  out  32  current TEST1 value.
ureg_wr_stb  out  1  one-cycle pulse on any committed write to TEST0/TEST1.

Behaviour:
- Register map (word offsets, addr[1:0] ignored): 0x00 FW_DATE RO, 0x04 FW_TIME RO, 0x08 TEST0 RW, 0x0C TEST1 RW; all other offsets are unmapped.
- Reset (ARESET=1 at a clock edge): all ready and valid outputs are 0, bresp and rresp are 0, rdata is 0, TEST0/TEST1 load their *_RST values, ureg_wr_stb is 0, and both FSMs go to IDLE. Reset wins over any in-flight handshake, and any transaction in progress is dropped with no response.
- Write FSM: W_IDLE, W_GOTA, W_GOTD, W_RESP.
  - In W_IDLE, awready and wready are both 1.
  - AW alone goes to W_GOTA: the address is latched, awready drops, and wready stays 1.
  - W alone goes to W_GOTD: data and strobes are latched, wready drops, and awready stays 1.
  - Both in the same cycle, or completion of the missing half, commits the write on that edge and moves to W_RESP with bvalid=1 on the next cycle.
  - Commit updates only the bytes whose wstrb bit is 1. A write to an RO or unmapped offset changes nothing.
  - ureg_wr_stb pulses for exactly one cycle coincident with bvalid rising, and only for a TEST0/TEST1 target with a nonzero wstrb.
  - In W_RESP, awready=wready=0. bvalid and bresp are held until bready, then the FSM returns to W_IDLE. The next AW/W is accepted no earlier than the cycle after the B handshake.
- Read FSM: R_IDLE, R_DATA.
  - In R_IDLE, arready=1. An AR handshake registers the decoded data and moves to R_DATA, so rvalid=1 one cycle after the handshake.
  - In R_DATA, arready=0 and rdata/rresp are held stable until rready, then the FSM returns to R_IDLE.
- Read and write channels are independent. When a read samples a register on the same edge that a write commits to it, the read returns the pre-write value.
- bresp and rresp are 2'b00 (OKAY) for mapped offsets.

Optional Feature:
Macro UREG_SLVERR_EN.
- Defined: unmapped reads return rdata=0 with rresp=2'b10 (SLVERR). Unmapped writes, and writes to RO offsets, return bresp=2'b10.
- Undefined: every access returns OKAY, unmapped reads return 0, and ignored writes are silent.

Test Plan:
- FW_DATE=32'h2024_0115, FW_TIME=32'h0013_4500; read 0x00 and 0x04 -> rdata 32'h2024_0115 then 32'h0013_4500, rresp 0, rvalid exactly one cycle after each AR handshake.
- Write 0x08=32'hDEADBEAF and 0x0C=32'h00A5A5A5 with wstrb=4'hF, then read both back -> 32'hDEADBEAF and 32'h00A5A5A5; ureg_wr_stb pulses twice; ureg_test0 equals 32'hDEADBEAF after the first B.
- Present W (32'h1122_3344, wstrb=4'b0101) three cycles before AW to 0x08 with TEST0=32'hDEADBEAF -> TEST0=32'hDE22BE44; bvalid is asserted only after AW is accepted.
- Hold bready=0 for 10 cycles after a write -> bvalid and bresp stay stable, awready/wready stay 0, and a second AW is not accepted until after the B handshake.
- Read 0x10 and write 0x00 -> with UREG_SLVERR_EN, rresp=2'b10, rdata=0, bresp=2'b10 and FW_DATE is unchanged; without the macro, both responses are 2'b00.
- Assert ARESET while in W_GOTA and while in R_DATA -> the next cycle has bvalid=rvalid=0 and TEST0/TEST1 equal to their *_RST values; awready, wready and arready return to 1 once ARESET is low.
